uart_tx_block: RTL and testbench
================================

# uart_tx_block

- Serializes bytes into a UART frame: start bit `0`, 8 data bits LSB first, then stop bit(s) `1`.
- Sits directly upstream of the receive block. Its `serial_out` drives the receiver's `serial_in` at the same bit rate, 10 clocks per bit by default.
- A one-entry holding register decouples the byte source from the shifter. This allows back-to-back frames with no idle gap between them.

## Interface
Parameters:
- `BIT_PERIOD`, default 10: clocks per serial bit; legal range ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `n_rst`  in  1  reset; synchronous, active-low.
- `tx_data`  in  8  byte to send; sampled only when `tx_load` is accepted.
- `tx_load`  in  1  load request; accepted when `tx_ready`=1.
- `tx_ready`  out  1  holding register empty.
- `tx_busy`  out  1  frame in progress (FSM not IDLE).
- `serial_out`  out  1  serial line; idles high.
- `tx_done`  out  1  one-cycle pulse at end of the last stop bit.
- `tx_overrun`  out  1  one-cycle pulse when `tx_load` is rejected.

## Operation
- All outputs are registered.
- Reset values: `serial_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, `tx_overrun`=0. Holding register is empty; FSM is in IDLE.
- **Holding register:**
  - `tx_load`=1 with `tx_ready`=1 captures `tx_data`; `tx_ready` goes 0 on the next cycle.
  - `tx_load`=1 with `tx_ready`=0: data is discarded and `tx_overrun` pulses the next cycle. Held data is unaffected.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** if the holding register is full, move its byte into the shift register, empty the holding register, and go to START.
  - **START:** `serial_out`=0 for `BIT_PERIOD` cycles, then go to DATA.
  - **DATA:** `serial_out` = shift[0] for `BIT_PERIOD` cycles per bit, then shift right. Bit index counts 0..7; after bit 7, go to STOP.
  - **STOP:** `serial_out`=1 for `STOP_BITS`×`BIT_PERIOD` cycles. On the final cycle, pulse `tx_done`.
    - If the holding register is full, load it and go directly to START, with no idle cycle.
    - Otherwise go to IDLE.
- **Counters:**
  - Bit-period counter: 0..`BIT_PERIOD`-1, width `$clog2(BIT_PERIOD)`; wraps and clears on every state change.
  - Bit index: 3 bits.
  - Stop-bit count: 1 bit.
- **Simultaneous events:**
  - A load in the same cycle the holding register is transferred is rejected, since `tx_ready` is still 0 that cycle.
  - A load accepted during a frame is sent immediately after that frame.
- **Reset mid-frame:** on the edge with `n_rst`=0, `serial_out` returns to 1 and the holding register is discarded. No `tx_done` is produced.

## Timing
- Load accepted at edge k: `serial_out` falls after edge k+2, i.e. two cycles of latency.
- Frame length is (9+`STOP_BITS`)×`BIT_PERIOD` cycles: 100 cycles with default parameters.
- `tx_done` is high during the last cycle of the stop bit.
- Back-to-back frames are contiguous: the next start bit begins on the cycle after the previous frame's last stop cycle.
- `tx_ready` returns to 1 one cycle after the holding-to-shift transfer.
- A new byte must be loaded ≥ 1 cycle before a frame ends to avoid a gap.
- `tx_busy` rises with the first START cycle and falls on the first IDLE cycle.

## Structure
- Shared package `uart_pkg` contains:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - `DEFAULT_BIT_PERIOD` = 10.
  - `DATA_BITS` = 8.
- Sub-module `flex_counter` is the bit-period timer. Rollover value is `BIT_PERIOD`-1; rollover flag goes to the FSM.
- Shift register, holding register and FSM live in `uart_tx_block`.

## Test plan
- **Reset:** hold `n_rst`=0 for 2 cycles → `serial_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, `tx_overrun`=0.
- **Single frame:** load 0xD5.
  - Sampled at bit centres, `serial_out` = 0,1,0,1,0,1,0,1,1,1.
  - Start bit falls 2 cycles after the load edge.
  - `tx_done` pulses at cycle 100 of the frame.
- **Back-to-back:** load 0xD5, then load 0x3C during the first frame's DATA state → 200 contiguous frame cycles with no idle high between the frames. Two `tx_done` pulses, 100 cycles apart.
- **Overrun:** load 0x11 in IDLE, 0x22 while busy, then 0x33 while the holding register is full.
  - `tx_overrun` pulses once.
  - Frames 0x11 and 0x22 are sent; 0x33 is never sent.
- **Loopback:** connect `serial_out` to the receive block's `serial_in`, `BIT_PERIOD`=10, send 0xA5 → receiver shows `rx_data`=0xA5, `data_ready`=1, `framing_error`=0, `overrun_error`=0.
- **Reset mid-frame:** assert `n_rst` during data bit 4 → `serial_out`=1 on the next edge, `tx_ready`=1, `tx_busy`=0, no `tx_done`. A subsequent load of 0x5A sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and frame-shape constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_BIT_PERIOD = 10;
  localparam int DATA_BITS          = 8;

endpackage

// File: rtl/flex_counter.sv
// Free-running bit-period timer that counts 0..ROLL_VAL and wraps to 0.
// Latency: o_rollover is high during the cycle the count sits at ROLL_VAL.
// Backpressure: none; i_clear forces the count to 0 and takes priority over counting.
module flex_counter #(
  parameter int W        = 4,
  parameter int ROLL_VAL = 9
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_rollover
);

  logic [W-1:0] r_count;
  logic         w_at_roll;

  assign w_at_roll  = (r_count == W'(ROLL_VAL));
  assign o_rollover = i_enable & w_at_roll;

  // Count up while enabled, wrapping at ROLL_VAL; clear restarts the period.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_roll ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits, with a one-byte holding register.
// Latency: serial_out falls two cycles after the load edge; a frame is (9+STOP_BITS)*BIT_PERIOD cycles.
// Backpressure: tx_ready=0 while the holding register is full; a load then is dropped and tx_overrun pulses.
module uart_tx_block
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       serial_out,
  output logic       tx_done,
  output logic       tx_overrun
);

  localparam int         CNT_W     = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);

  tx_state_t  r_state;
  tx_state_t  w_next_state;
  logic [7:0] r_hold;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_stop_cnt;
  logic       r_tx_ready;
  logic       r_tx_busy;
  logic       r_serial_out;
  logic       r_tx_done;
  logic       r_tx_overrun;

  logic       w_roll;
  logic       w_accept;
  logic       w_xfer;
  logic       w_frame_end;
  logic       w_cnt_clear;

  // r_tx_ready doubles as "holding register empty".
  assign w_accept    = tx_load & r_tx_ready;
  // Timer restarts on every state change and is parked at 0 while idle.
  assign w_cnt_clear = (w_next_state != r_state) || (r_state == IDLE);

  flex_counter #(
    .W        (CNT_W),
    .ROLL_VAL (BIT_PERIOD - 1)
  ) u_bit_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_clear    (w_cnt_clear),
    .i_enable   (1'b1),
    .o_rollover (w_roll)
  );

  // Next-state logic; a full holding register chains straight from STOP into START.
  always_comb begin
    w_next_state = r_state;
    w_xfer       = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_tx_ready) begin
          w_next_state = START;
          w_xfer       = 1'b1;
        end
      end
      START: begin
        if (w_roll) begin
          w_next_state = DATA;
        end
      end
      DATA: begin
        if (w_roll && (r_bit_idx == LAST_BIT)) begin
          w_next_state = STOP;
        end
      end
      STOP: begin
        if (w_roll && (r_stop_cnt == LAST_STOP)) begin
          w_frame_end = 1'b1;
          if (!r_tx_ready) begin
            w_next_state = START;
            w_xfer       = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, holding register, shifter and bit/stop counters.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_state <= w_next_state;
      // Transfer and accept are exclusive: transfer needs the register full, accept needs it empty.
      if (w_xfer) begin
        r_shift    <= r_hold;
        r_tx_ready <= 1'b1;
      end else if (w_accept) begin
        r_hold     <= tx_data;
        r_tx_ready <= 1'b0;
      end
      if ((r_state == DATA) && w_roll) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if ((r_state == STOP) && w_roll) begin
        r_stop_cnt <= (r_stop_cnt == LAST_STOP) ? 1'b0 : ~r_stop_cnt;
      end
    end
  end

  // Registered outputs: a one-cycle-delayed view of the FSM, so all outputs stay aligned.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_serial_out <= 1'b1;
      r_tx_busy    <= 1'b0;
      r_tx_done    <= 1'b0;
      r_tx_overrun <= 1'b0;
    end else begin
      case (r_state)
        START:   r_serial_out <= 1'b0;
        DATA:    r_serial_out <= r_shift[0];
        default: r_serial_out <= 1'b1;
      endcase
      r_tx_busy    <= (r_state != IDLE);
      r_tx_done    <= w_frame_end;
      r_tx_overrun <= tx_load & ~r_tx_ready;
    end
  end

  assign tx_ready   = r_tx_ready;
  assign tx_busy    = r_tx_busy;
  assign serial_out = r_serial_out;
  assign tx_done    = r_tx_done;
  assign tx_overrun = r_tx_overrun;

endmodule

// File: tb/tb_uart_tx_block.sv
// Directed bench for uart_tx_block with default parameters (10 clocks/bit, 1 stop bit).
// Each scenario records the outputs cycle by cycle after the load edge, then checks them.
// Frame cycle f of a frame loaded at capture index 0 appears at capture index f+1.
module tb_uart_tx_block;

  localparam int N = 260;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, serial_out, tx_done, tx_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic cap_ser [N];
  logic cap_rdy [N];
  logic cap_busy[N];
  logic cap_done[N];
  logic cap_ovr [N];

  int         ld_at [3];
  logic [7:0] ld_dat[3];
  int         rst_at;

  always #5 clk = ~clk;

  uart_tx_block dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .serial_out (serial_out),
    .tx_done    (tx_done),
    .tx_overrun (tx_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_plan();
    for (int j = 0; j < 3; j++) begin
      ld_at[j]  = -1;
      ld_dat[j] = 8'h00;
    end
    rst_at = -1;
  endtask

  // Drive the planned loads/reset and record outputs #1 after each of n rising edges.
  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      tx_load = 1'b0;
      n_rst   = 1'b1;
      for (int j = 0; j < 3; j++) begin
        if (ld_at[j] == i) begin
          tx_load = 1'b1;
          tx_data = ld_dat[j];
        end
      end
      if (i == rst_at) n_rst = 1'b0;
      @(posedge clk);
      #1;
      cap_ser[i]  = serial_out;
      cap_rdy[i]  = tx_ready;
      cap_busy[i] = tx_busy;
      cap_done[i] = tx_done;
      cap_ovr[i]  = tx_overrun;
    end
    tx_load = 1'b0;
    n_rst   = 1'b1;
  endtask

  // Line level for bit slot b of a frame carrying d (0 = start, 1..8 = data, 9 = stop).
  function automatic logic fbit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return d[b-1];
  endfunction

  // Check the bit-centre samples of one frame whose frame cycle 1 is capture index off+1.
  task automatic check_frame(input string tag, input int off, input logic [7:0] d);
    for (int b = 0; b < 10; b++) begin
      check($sformatf("%s bit%0d", tag, b), 32'(cap_ser[off + 10*b + 5]), 32'(fbit(d, b)));
    end
  endtask

  function automatic int count_done(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (cap_done[i]) c++;
    return c;
  endfunction

  function automatic int count_ovr(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (cap_ovr[i]) c++;
    return c;
  endfunction

  function automatic int count_low(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (!cap_ser[i]) c++;
    return c;
  endfunction

  initial begin
    int         errs;
    int         idle_busy;
    logic [7:0] rx;

    // Reset state
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst serial_out", 32'(serial_out), 32'd1);
    check("rst tx_ready",   32'(tx_ready),   32'd1);
    check("rst tx_busy",    32'(tx_busy),    32'd0);
    check("rst tx_done",    32'(tx_done),    32'd0);
    check("rst tx_overrun", 32'(tx_overrun), 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Single frame 0xD5
    clear_plan();
    ld_at[0] = 0; ld_dat[0] = 8'hD5;
    cap(115);
    check("single ready after load",  32'(cap_rdy[0]),   32'd0);
    check("single ready after xfer",  32'(cap_rdy[1]),   32'd1);
    check("single line high k+1",     32'(cap_ser[1]),   32'd1);
    check("single start falls k+2",   32'(cap_ser[2]),   32'd0);
    check("single busy before start", 32'(cap_busy[1]),  32'd0);
    check("single busy at start",     32'(cap_busy[2]),  32'd1);
    check_frame("single D5", 1, 8'hD5);
    check("single done cycle 99",     32'(cap_done[100]), 32'd0);
    check("single done cycle 100",    32'(cap_done[101]), 32'd1);
    check("single done count",        32'(count_done(0, 114)), 32'd1);
    check("single busy last stop",    32'(cap_busy[101]), 32'd1);
    check("single busy first idle",   32'(cap_busy[102]), 32'd0);
    check("single line idle after",   32'(count_low(102, 114)), 32'd0);

    // Back-to-back 0xD5 then 0x3C loaded during DATA
    clear_plan();
    ld_at[0] = 0;  ld_dat[0] = 8'hD5;
    ld_at[1] = 30; ld_dat[1] = 8'h3C;
    cap(215);
    check("b2b second accepted",  32'(cap_rdy[30]), 32'd0);
    check("b2b no overrun",       32'(count_ovr(0, 214)), 32'd0);
    check("b2b ready before xfer", 32'(cap_rdy[100]), 32'd0);
    check("b2b ready after xfer",  32'(cap_rdy[101]), 32'd1);
    errs = 0;
    idle_busy = 0;
    for (int f = 1; f <= 200; f++) begin
      if (cap_ser[f+1] !== fbit((f <= 100) ? 8'hD5 : 8'h3C, ((f - 1) % 100) / 10)) errs++;
      if (!cap_busy[f+1]) idle_busy++;
    end
    check("b2b contiguous line mismatches", 32'(errs), 32'd0);
    check("b2b busy gaps", 32'(idle_busy), 32'd0);
    check_frame("b2b D5", 1,   8'hD5);
    check_frame("b2b 3C", 101, 8'h3C);
    check("b2b done 1",     32'(cap_done[101]), 32'd1);
    check("b2b done 2",     32'(cap_done[201]), 32'd1);
    check("b2b done count", 32'(count_done(0, 214)), 32'd2);
    check("b2b idle line",  32'(cap_ser[202]), 32'd1);
    check("b2b busy falls", 32'(cap_busy[202]), 32'd0);

    // Overrun: 0x11 idle, 0x22 while busy, 0x33 while holding register full
    clear_plan();
    ld_at[0] = 0;  ld_dat[0] = 8'h11;
    ld_at[1] = 20; ld_dat[1] = 8'h22;
    ld_at[2] = 40; ld_dat[2] = 8'h33;
    cap(260);
    check("ovr 0x22 accepted",  32'(cap_rdy[20]), 32'd0);
    check("ovr pulse on 0x33",  32'(cap_ovr[40]), 32'd1);
    check("ovr pulse count",    32'(count_ovr(0, 259)), 32'd1);
    check_frame("ovr 11", 1,   8'h11);
    check_frame("ovr 22", 101, 8'h22);
    check("ovr done count",     32'(count_done(0, 259)), 32'd2);
    check("ovr no third frame", 32'(count_low(202, 259)), 32'd0);

    // Loopback-style decode of 0xA5 at bit centres
    clear_plan();
    ld_at[0] = 0; ld_dat[0] = 8'hA5;
    cap(110);
    rx = 8'h00;
    for (int b = 1; b <= 8; b++) rx[b-1] = cap_ser[1 + 10*b + 5];
    check("loop rx_data",       32'(rx), 32'hA5);
    check("loop start bit",     32'(cap_ser[6]),  32'd0);
    check("loop stop bit",      32'(cap_ser[96]), 32'd1);
    check("loop done count",    32'(count_done(0, 109)), 32'd1);
    check("loop overrun count", 32'(count_ovr(0, 109)), 32'd0);

    // Reset during data bit 4 of 0xE0, then a clean 0x5A frame
    clear_plan();
    ld_at[0] = 0; ld_dat[0] = 8'hE0;
    rst_at = 56;
    cap(120);
    check("mid line low in bit4",   32'(cap_ser[55]),  32'd0);
    check("mid rst serial_out",     32'(cap_ser[56]),  32'd1);
    check("mid rst tx_ready",       32'(cap_rdy[56]),  32'd1);
    check("mid rst tx_busy",        32'(cap_busy[56]), 32'd0);
    check("mid no done",            32'(count_done(0, 119)), 32'd0);
    check("mid line idle after",    32'(count_low(56, 119)), 32'd0);
    clear_plan();
    ld_at[0] = 0; ld_dat[0] = 8'h5A;
    cap(110);
    check("post start latency", 32'(cap_ser[2]), 32'd0);
    check_frame("post 5A", 1, 8'h5A);
    check("post done",          32'(cap_done[101]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
